// File: rtl/dbg_seq_pkg.sv
// Shared opcodes, sequencer state encoding and counter sizing for the
// debug halt/resume sequencer.
package dbg_seq_pkg;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_HALT   = 2'b01;
  localparam logic [1:0] OP_RESUME = 2'b10;
  localparam logic [1:0] OP_STEP   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    HALT_WAIT,
    RESUME_PULSE,
    RESUME_WAIT,
    FINISH
  } state_t;

  // Width needed to hold TIMEOUT_CYCLES-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles <= 2) ? 1 : int'($clog2(cycles));
  endfunction

endpackage

// File: rtl/dbg_timeout_counter.sv
// Loadable down-counter that holds at zero; zero flag decodes the register.
module dbg_timeout_counter #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dbg_halt_sequencer.sv
// Sequences halt/resume/step of a group of cores through their debug
// request/acknowledge pairs, with a shared per-command timeout.
module dbg_halt_sequencer
  import dbg_seq_pkg::*;
#(
  parameter int unsigned NUM_CPU        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [NUM_CPU-1:0] cmd_mask,
  input  logic [NUM_CPU-1:0] debugack,
  output logic [NUM_CPU-1:0] debugreq,
  output logic [NUM_CPU-1:0] resume_req,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic [NUM_CPU-1:0] halted_mask
);

  localparam int unsigned    CW       = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [1:0]           op;
  logic [NUM_CPU-1:0]   mask;
  logic [NUM_CPU-1:0]   held_mask;
  logic                 accept;
  logic                 in_wait;
  logic                 cnt_zero;
  logic                 halt_ok;
  logic                 resume_ok;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign in_wait   = (state == HALT_WAIT) || (state == RESUME_WAIT);
  assign halt_ok   = ((halted_mask & mask) == mask);
  assign resume_ok = ((halted_mask & mask) == '0);

  dbg_timeout_counter #(
    .WIDTH(CW)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .load_value(LOAD_VAL),
    .dec       (in_wait),
    .zero      (cnt_zero)
  );

  // debugreq is registered, so each transition writes the value the new
  // state implies: held_mask plus the latched mask while in HALT_WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op          <= OP_NOP;
      mask        <= '0;
      held_mask   <= '0;
      debugreq    <= '0;
      resume_req  <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      halted_mask <= '0;
    end else begin
      halted_mask <= debugack;
      done        <= 1'b0;
      resume_req  <= '0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            op          <= cmd_op;
            mask        <= cmd_mask;
            err_timeout <= 1'b0;
            if ((cmd_op == OP_NOP) || (cmd_mask == '0)) begin
              state <= FINISH;
              done  <= 1'b1;
            end else if (cmd_op == OP_RESUME) begin
              state      <= RESUME_PULSE;
              held_mask  <= held_mask & ~cmd_mask;
              debugreq   <= held_mask & ~cmd_mask;
              resume_req <= cmd_mask;
            end else begin
              state    <= HALT_WAIT;
              debugreq <= held_mask | cmd_mask;
            end
          end
        end
        HALT_WAIT: begin
          if (halt_ok) begin
            if (op == OP_STEP) begin
              state      <= RESUME_PULSE;
              held_mask  <= held_mask & ~mask;
              debugreq   <= held_mask & ~mask;
              resume_req <= mask;
            end else begin
              state     <= FINISH;
              done      <= 1'b1;
              held_mask <= held_mask | mask;
              debugreq  <= held_mask | mask;
            end
          end else if (cnt_zero) begin
            state       <= FINISH;
            done        <= 1'b1;
            err_timeout <= 1'b1;
            debugreq    <= held_mask;
          end
        end
        RESUME_PULSE: begin
          state <= RESUME_WAIT;
        end
        RESUME_WAIT: begin
          if (resume_ok) begin
            state <= FINISH;
            done  <= 1'b1;
          end else if (cnt_zero) begin
            state       <= FINISH;
            done        <= 1'b1;
            err_timeout <= 1'b1;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_halt_sequencer.sv
// Bench for dbg_halt_sequencer: directed command table, a reset-in-flight
// sequence and random commands checked against a cycle-search reference model.
module tb_dbg_halt_sequencer;
  import dbg_seq_pkg::*;

  localparam int N     = 2;
  localparam int TC    = 8;
  localparam int NEVER = 1000000;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [N-1:0] cmd_mask;
  logic [N-1:0] debugack;
  logic [N-1:0] debugreq;
  logic [N-1:0] resume_req;
  logic         busy;
  logic         done;
  logic         err_timeout;
  logic [N-1:0] halted_mask;

  dbg_halt_sequencer #(
    .NUM_CPU       (N),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_mask   (cmd_mask),
    .debugack   (debugack),
    .debugreq   (debugreq),
    .resume_req (resume_req),
    .busy       (busy),
    .done       (done),
    .err_timeout(err_timeout),
    .halted_mask(halted_mask)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Core model: ack level per cycle from a resting level plus scheduled edges.
  bit           base   [N];
  int           rise_t [N];
  int           fall_t [N];
  logic [N-1:0] m_held;

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [N-1:0] mask;
    int           rd [N];
    int           fd [N];
    int           done_off;
    int           err;
    int           dreq;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic bit ack_lvl(input int i, input int x);
    return (x < fall_t[i]) && ((x >= rise_t[i]) || base[i]);
  endfunction

  function automatic bit all_acked(input logic [N-1:0] m, input int x);
    for (int i = 0; i < N; i++) if (m[i] && !ack_lvl(i, x)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit none_acked(input logic [N-1:0] m, input int x);
    for (int i = 0; i < N; i++) if (m[i] && ack_lvl(i, x)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) debugack[i] = ack_lvl(i, cyc);
  endtask

  // Reference: scan cycles after accept t0 for the completion condition,
  // with one budget of TC wait cycles shared by both phases.
  task automatic predict(input logic [1:0] op, input logic [N-1:0] m, input int fd [N],
                         input int t0, output int e_done, output bit e_err,
                         output int e_pulse);
    int  k_done;
    int  cnt0;
    int  s;
    bit  ok;
    e_pulse = -1;
    e_err   = 1'b0;
    e_done  = t0 + 1;
    k_done  = 0;
    if (op == OP_NOP || m == '0) return;
    cnt0 = TC - 1;
    s    = t0 + 2;
    if (op != OP_RESUME) begin
      ok = 1'b0;
      for (int k = 0; k < TC && !ok; k++)
        if (all_acked(m, t0 + k)) begin ok = 1'b1; k_done = k; end
      if (!ok) begin
        e_done = t0 + TC + 1;
        e_err  = 1'b1;
        return;
      end
      if (op == OP_HALT) begin
        e_done = t0 + k_done + 2;
        m_held = m_held | m;
        return;
      end
      e_pulse = t0 + k_done + 2;
      cnt0    = (TC - 2 - k_done > 0) ? TC - 2 - k_done : 0;
      s       = e_pulse + 1;
    end else begin
      e_pulse = t0 + 1;
    end
    m_held = m_held & ~m;
    for (int i = 0; i < N; i++) if (m[i] && fd[i] > 0) fall_t[i] = e_pulse + fd[i];
    ok = 1'b0;
    for (int j = 0; j <= cnt0 && !ok; j++)
      if (none_acked(m, s + j - 1)) begin ok = 1'b1; e_done = s + j + 1; end
    if (!ok) begin
      e_done = s + cnt0 + 1;
      e_err  = 1'b1;
    end
  endtask

  task automatic settle();
    int last;
    last = -1;
    for (int i = 0; i < N; i++) begin
      if (rise_t[i] < NEVER && rise_t[i] > last) last = rise_t[i];
      if (fall_t[i] < NEVER && fall_t[i] > last) last = fall_t[i];
    end
    while (cyc <= last) step();
    for (int i = 0; i < N; i++) begin
      base[i]   = ack_lvl(i, cyc);
      rise_t[i] = NEVER;
      fall_t[i] = NEVER;
    end
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [N-1:0] m,
                         input int rd [N], input int fd [N], input bit hold_valid,
                         output int lat, output int err_o, output int dreq_o);
    int           t0, e_done, e_pulse, pulses, pulse_at, done_at;
    bit           e_err;
    logic [N-1:0] held0, e_dreq1, pulse_val, e_halted;
    check({tag, "_ready"}, int'(cmd_ready), 1);
    t0    = cyc;
    held0 = m_held;
    if (op == OP_HALT || op == OP_STEP)
      for (int i = 0; i < N; i++) if (m[i] && rd[i] > 0) rise_t[i] = t0 + rd[i];
    predict(op, m, fd, t0, e_done, e_err, e_pulse);
    if (op == OP_NOP || m == '0) e_dreq1 = held0;
    else if (op == OP_RESUME)    e_dreq1 = held0 & ~m;
    else                         e_dreq1 = held0 | m;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = m;
    step();
    if (hold_valid) begin
      cmd_op   = 2'($urandom);
      cmd_mask = N'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
    check({tag, "_dreq_t1"}, int'(debugreq), int'(e_dreq1));
    check({tag, "_err_clr"}, int'(err_timeout), 0);
    pulses    = 0;
    pulse_at  = -1;
    pulse_val = '0;
    done_at   = -1;
    for (int w = 0; w < 4 * TC + 20 && done_at < 0; w++) begin
      if (resume_req != '0) begin
        pulses++;
        pulse_at  = cyc;
        pulse_val = resume_req;
      end
      if (done) begin
        done_at   = cyc;
        cmd_valid = 1'b0;
      end else begin
        step();
      end
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < N; i++) e_halted[i] = ack_lvl(i, cyc - 1);
    check({tag, "_done_cycle"}, done_at - t0, e_done - t0);
    check({tag, "_err"}, int'(err_timeout), int'(e_err));
    check({tag, "_dreq_end"}, int'(debugreq), int'(m_held));
    check({tag, "_halted"}, int'(halted_mask), int'(e_halted));
    check({tag, "_pulses"}, pulses, (e_pulse < 0) ? 0 : 1);
    if (e_pulse >= 0) begin
      check({tag, "_pulse_cycle"}, pulse_at - t0, e_pulse - t0);
      check({tag, "_pulse_val"}, int'(pulse_val), int'(m));
    end
    lat    = done_at - t0;
    err_o  = int'(err_timeout);
    dreq_o = int'(debugreq);
    step();
    check({tag, "_done_len"}, int'(done), 0);
    check({tag, "_ready_back"}, int'(cmd_ready), 1);
    settle();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int lat, errv, dreqv;
    int zrd [N];
    vecs[0] = '{"halt11",    OP_HALT,   2'b11, '{3, 5}, '{0, 0}, 7, 0, 3};
    vecs[1] = '{"resume01",  OP_RESUME, 2'b01, '{0, 0}, '{3, 0}, 6, 0, 2};
    vecs[2] = '{"resume10",  OP_RESUME, 2'b10, '{0, 0}, '{0, 2}, 5, 0, 0};
    vecs[3] = '{"halt10_to", OP_HALT,   2'b10, '{0, 0}, '{0, 0}, 9, 1, 0};
    vecs[4] = '{"step01",    OP_STEP,   2'b01, '{2, 0}, '{3, 0}, 9, 0, 0};
    vecs[5] = '{"nop",       OP_NOP,    2'b11, '{0, 0}, '{0, 0}, 1, 0, 0};
    vecs[6] = '{"halt_zero", OP_HALT,   2'b00, '{0, 0}, '{0, 0}, 1, 0, 0};
    zrd = '{0, 0};

    for (int i = 0; i < N; i++) begin
      base[i]   = 1'b0;
      rise_t[i] = NEVER;
      fall_t[i] = NEVER;
    end
    m_held    = '0;
    debugack  = '0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_mask  = '0;
    step();
    step();
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_dreq", int'(debugreq), 0);
    check("rst_resume", int'(resume_req), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err_timeout), 0);
    check("rst_halted", int'(halted_mask), 0);
    reset = 1'b0;
    step();

    for (int v = 0; v < 7; v++) begin
      run_cmd(vecs[v].name, vecs[v].op, vecs[v].mask, vecs[v].rd, vecs[v].fd,
              (v % 2) == 1, lat, errv, dreqv);
      check({vecs[v].name, "_tbl_lat"}, lat, vecs[v].done_off);
      check({vecs[v].name, "_tbl_err"}, errv, vecs[v].err);
      check({vecs[v].name, "_tbl_dreq"}, dreqv, vecs[v].dreq);
    end

    // Reset while a HALT is waiting, with core 1 sitting in debug mode.
    base[1] = 1'b1;
    step();
    cmd_valid = 1'b1;
    cmd_op    = OP_HALT;
    cmd_mask  = 2'b01;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    check("mid_dreq", int'(debugreq), 1);
    check("mid_busy", int'(busy), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_ready", int'(cmd_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_dreq", int'(debugreq), 0);
    check("mid_rst_resume", int'(resume_req), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_err", int'(err_timeout), 0);
    check("mid_rst_halted", int'(halted_mask), 0);
    m_held = '0;
    run_cmd("post_rst_halt", OP_HALT, 2'b01, '{2, 0}, zrd, 1'b0, lat, errv, dreqv);
    check("post_rst_lat", lat, 4);
    check("post_rst_dreq", dreqv, 1);

    for (int r = 0; r < 80; r++) begin
      int           rd [N];
      int           fd [N];
      logic [1:0]   op;
      logic [N-1:0] m;
      op = 2'($urandom_range(0, 3));
      m  = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        rd[i] = int'($urandom_range(1, 10));
        fd[i] = int'($urandom_range(0, 11));
      end
      run_cmd($sformatf("rnd%0d", r), op, m, rd, fd, bit'($urandom_range(0, 1)),
              lat, errv, dreqv);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dbg_halt_sequencer.md
# dbg_halt_sequencer

Sequences coordinated halt and resume of the Nios II cores in the multi-processor image pipeline through each core's debug request/acknowledge pair. It sits in the system clock domain beside each core's debug slave. It accepts one command at a time from a host-side control register block, then drives per-core `debugreq` and `resume_req`. It waits for the matching `debugack` transitions and reports completion or timeout.

## Interface
- `NUM_CPU`, default 2: number of sequenced cores.
- `TIMEOUT_CYCLES`, default 1024: maximum wait cycles per command; must be ≥ 2.
- `clk` input, 1 bit: single system clock. All I/O is synchronous to it.
- `reset` input, 1 bit: synchronous, active-high reset.
- `cmd_valid` input, 1 bit: command offered.
- `cmd_ready` output, 1 bit: block can accept a command.
- `cmd_op` input, 2 bits: command code. 00 NOP, 01 HALT, 10 RESUME, 11 STEP (halt, then resume).
- `cmd_mask` input, NUM_CPU bits: target cores.
- `debugack` input, NUM_CPU bits: per-core "in debug mode".
- `debugreq` output, NUM_CPU bits: per-core halt request, level.
- `resume_req` output, NUM_CPU bits: per-core resume pulse.
- `busy` output, 1 bit: command in progress.
- `done` output, 1 bit: one-cycle pulse when a command ends.
- `err_timeout` output, 1 bit: sticky timeout flag, cleared on next accept.
- `halted_mask` output, NUM_CPU bits: registered copy of `debugack`.

## Operation
- States:
  - IDLE
  - HALT_WAIT
  - RESUME_PULSE
  - RESUME_WAIT
  - FINISH
- Accept condition: `cmd_valid && cmd_ready`. `cmd_ready` = (state == IDLE). On accept, latch `cmd_op` and `cmd_mask`, load the timeout counter with TIMEOUT_CYCLES−1, and clear `err_timeout`.
- Transitions out of IDLE on accept:
  - NOP → FINISH.
  - `cmd_mask` == 0 (any op) → FINISH, with no request outputs driven.
  - HALT, STEP → HALT_WAIT.
  - RESUME → RESUME_PULSE.
- HALT_WAIT:
  - `debugreq` = latched mask.
  - Complete when (`halted_mask` & mask) == mask. HALT then goes to FINISH; STEP goes to RESUME_PULSE.
- RESUME_PULSE:
  - `resume_req` = mask for exactly one cycle; `debugreq` = 0.
  - Then go to RESUME_WAIT.
- RESUME_WAIT:
  - Complete when (`halted_mask` & mask) == 0, then go to FINISH.
- Timeout:
  - The counter decrements every cycle in HALT_WAIT or RESUME_WAIT.
  - If it is 0 in a wait state and the completion condition is false, set `err_timeout`, drop `debugreq` to 0, and go to FINISH.
  - If completion and counter == 0 occur in the same cycle, completion wins and no error is raised.
  - STEP uses one counter load for both wait phases; the counter is not reloaded between them.
- FINISH: pulse `done`, then go to IDLE.
- Persistence: after a successful HALT, `debugreq` stays asserted for the latched mask until the next RESUME or STEP targeting those cores is accepted.
  - Tracking: a HALT leaves a `held_mask` register = mask.
  - RESUME/STEP clears the `held_mask` bits of its own mask at entry to RESUME_PULSE.
  - `debugreq` = `held_mask` | (HALT_WAIT ? mask : 0).
- `cmd_valid` while busy is ignored. `cmd_op`/`cmd_mask` changes after accept have no effect.
- Reset, including mid-command, sets:
  - state IDLE, `held_mask` 0, counter 0;
  - `debugreq`, `resume_req`, `busy`, `done`, `err_timeout`, `halted_mask` all 0;
  - `cmd_ready` 1.

## Timing
- All outputs are registered except `cmd_ready` and `busy`, which decode directly from the state register.
- Accept in cycle T:
  - `debugreq` is high from T+1.
  - `halted_mask` lags `debugack` by one cycle.
- HALT where ack rises at cycle A:
  - `halted_mask` is high at A+1.
  - Completion is detected at A+1 and FINISH is at A+2.
  - `done` is high at A+2; `cmd_ready` returns at A+3.
- RESUME accepted at T:
  - `resume_req` is high only at T+1.
  - When ack falls at F, `done` is high at F+2.
- NOP or zero mask accepted at T: `done` at T+1, `cmd_ready` at T+2.
- Timeout: `done` is asserted exactly TIMEOUT_CYCLES+1 cycles after the accept cycle. `err_timeout` rises in the same cycle as `done`.
- Back-to-back: the next accept is possible in the cycle after `done`.

## Structure
- Shared package `dbg_seq_pkg` holds:
  - opcode constants OP_NOP/OP_HALT/OP_RESUME/OP_STEP;
  - the state enum;
  - a counter-width function, clog2(TIMEOUT_CYCLES).
- Sub-module `dbg_timeout_counter`: load, decrement-enable and zero flag.
- Everything else lives in the top FSM.

## Test plan
- HALT mask=2'b11; ack[0] rises at +3 and ack[1] at +5 → `debugreq`=11 from T+1, `done` at T+7, `err_timeout`=0, `debugreq` stays 11 afterwards.
- RESUME mask=2'b01 after that halt → `resume_req`=01 for one cycle; `debugreq` becomes 10; ack[0] falls at +4 → `done` at T+6.
- HALT mask=2'b10 with TIMEOUT_CYCLES=8 and ack never rising → `done` and `err_timeout`=1 at T+9; `debugreq`[1] drops to 0.
- STEP mask=2'b01; ack rises at +2 and falls 3 cycles after the `resume_req` pulse → one `done`, no error, `held_mask` ends at 0.
- NOP, then zero-mask HALT back-to-back → `done` at T+1 each; no `debugreq`/`resume_req` activity; `cmd_valid` held during busy is not double-accepted.
- `reset` asserted during HALT_WAIT → next cycle all outputs 0 and `cmd_ready`=1; a fresh HALT after reset completes normally.
